// File: rtl/des_sbox_pkg.sv
`default_nettype none
// =============================================================================
// Module   : des_sbox_pkg
// Purpose  : Shared widths, FSM state encoding and ROM addressing helper for
//            the time-multiplexed DES S-box controller.
// Revision : 1.0 - initial release
// =============================================================================
package des_sbox_pkg;

    localparam int SBOX_IDX_W = 3;
    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 4;
    localparam int NUM_SBOX   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Group a[6:1] -> {row, col} = {a[6], a[1], a[5:2]}
    function automatic logic [SBOX_IN_W-1:0] sbox_rom_addr(input logic [SBOX_IN_W-1:0] a);
        return {a[5], a[0], a[4:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_sbox_rom.sv
`default_nettype none
// =============================================================================
// Module   : des_sbox_rom
// Purpose  : Combinational lookup of all eight DES S-boxes, table chosen by sel.
// Revision : 1.0 - initial release
// =============================================================================
module des_sbox_rom
    import des_sbox_pkg::*;
(
    input  logic [SBOX_IDX_W-1:0] sel,
    input  logic [SBOX_IN_W:1]    addr,
    output logic [SBOX_OUT_W:1]   dout
);

    // Each table is 64 nibbles, entry {row,col}=0 in the most significant nibble.
    localparam logic [255:0] c_tab [NUM_SBOX] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    logic [SBOX_IN_W-1:0] w_rom_addr;
    logic [255:0]         w_tab;

    assign w_rom_addr = sbox_rom_addr(addr);
    assign w_tab      = c_tab[sel];
    // MSB of entry n sits at bit 255-4n = {~n, 2'b11}
    assign dout       = w_tab[{~w_rom_addr, 2'b11} -: SBOX_OUT_W];

endmodule
`default_nettype wire

// File: rtl/des_sbox_seq.sv
`default_nettype none
// =============================================================================
// Module   : des_sbox_seq
// Purpose  : Sequences a 48-bit DES expansion word through a shared S-box ROM
//            and returns the 32-bit S-layer result. DES_SBOX_DUAL_EN selects
//            two ROM instances (two groups per cycle).
// Revision : 1.0 - initial release
// =============================================================================
module des_sbox_seq
    import des_sbox_pkg::*;
#(
    parameter int OUT_REG = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

`ifdef DES_SBOX_DUAL_EN
    localparam int c_grp = 2;
`else
    localparam int c_grp = 1;
`endif
    localparam int                    c_dw       = SBOX_IN_W * c_grp;
    localparam int                    c_rw       = SBOX_OUT_W * c_grp;
    localparam logic [SBOX_IDX_W-1:0] c_idx_last = SBOX_IDX_W'(NUM_SBOX / c_grp - 1);

    state_e                r_state, w_state_nxt;
    logic [SBOX_IDX_W-1:0] r_idx, w_idx_nxt;
    logic                  r_tail, w_tail_nxt;
    logic                  w_load, w_step, w_kill;
    logic [47:0]           r_data;
    logic [31:0]           r_result;
    logic [c_rw-1:0]       w_nib;

    assign w_kill = rst | abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_tail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tail_nxt  = r_tail;
        w_load      = 1'b0;
        w_step      = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                // r_tail marks the extra cycle spent loading the output stage
                if (r_tail) begin
                    w_tail_nxt  = 1'b0;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_step = 1'b1;
                    if (r_idx == c_idx_last) begin
                        if (OUT_REG != 0) begin
                            w_tail_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load      = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Flush overrides every handshake so nothing is accepted or delivered
        if (w_kill) begin
            in_ready    = 1'b0;
            out_valid   = 1'b0;
            w_load      = 1'b0;
            w_step      = 1'b0;
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_tail_nxt  = 1'b0;
        end
    end

    // Current groups always sit at the top of r_data; results shift in from the LSB
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_result <= '0;
        end else begin
            if (w_load) begin
                r_data <= in_data;
            end else if (w_step) begin
                r_data <= {r_data[47-c_dw:0], {c_dw{1'b0}}};
            end
            if (w_step) begin
                r_result <= {r_result[31-c_rw:0], w_nib};
            end
        end
    end

    for (genvar g = 0; g < c_grp; g++) begin : g_rom
        logic [SBOX_IDX_W-1:0] w_sel;
        assign w_sel = SBOX_IDX_W'(32'(r_idx) * c_grp + g);
        des_sbox_rom u_rom (
            .sel  (w_sel),
            .addr (r_data[47-SBOX_IN_W*g -: SBOX_IN_W]),
            .dout (w_nib[c_rw-1-SBOX_OUT_W*g -: SBOX_OUT_W])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [31:0] r_out;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_out <= '0;
            end else if (r_state == ST_RUN && r_tail && !abort) begin
                r_out <= r_result;
            end
        end
        assign out_data = r_out;
    end else begin : g_out_comb
        assign out_data = r_result;
    end

endmodule
`default_nettype wire

// File: tb/tb_des_sbox_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_des_sbox_seq
// Purpose  : Scoreboard bench for des_sbox_seq against a table-driven DES
//            S-layer model (honours DES_SBOX_DUAL_EN).
// Revision : 1.0 - initial release
// =============================================================================
module tb_des_sbox_seq;

    localparam int OUT_REG = 0;
`ifdef DES_SBOX_DUAL_EN
    localparam int c_run = 4;
`else
    localparam int c_run = 8;
`endif
    localparam int c_lat = c_run + 1 + OUT_REG;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, abort, out_valid, out_ready, busy;
    logic [47:0] in_data;
    logic [31:0] out_data;

    des_sbox_seq #(.OUT_REG(OUT_REG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Standard DES S-boxes, row-major: entry = row*16 + col
    int sb [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] ref_slayer(input logic [47:0] x);
        logic [31:0] r;
        int          a, row, col;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            a   = int'((x >> (42 - 6*k)) & 48'h3F);
            row = ((a >> 5) & 1) * 2 + (a & 1);
            col = (a >> 1) & 15;
            r   = (r << 4) | 32'(sb[k][row*16 + col]);
        end
        return r;
    endfunction

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] cur_exp = '0;
    bit          seen    = 1'b0;
    bit          b2b     = 1'b0;
    bit          have_last = 1'b0;
    int          last_acc  = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples mid-cycle, sees exactly what the next edge will commit
    always @(negedge clk) begin
        if (rst || abort) begin
            exp_q.delete();
            seen = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got out_data %h with no word pending (cycle %0d)", out_data, cyc);
                end else begin
                    e = exp_q[0];
                    if (!seen) begin
                        chk("latency", 48'(cyc - e.acc), 48'(c_lat));
                        seen = 1'b1;
                    end
                    chk("out_data", 48'(out_data), 48'(e.data));
                    chk("busy_done", 48'(busy), 48'd1);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.data = cur_exp;
                e.acc  = cyc;
                exp_q.push_back(e);
                if (b2b && have_last) chk("throughput", 48'(cyc - last_acc), 48'(c_lat));
                last_acc  = cyc;
                have_last = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [47:0] d, input logic [31:0] x);
        int   n;
        logic got;
        n        = 0;
        got      = 1'b0;
        cur_exp  = x;
        in_valid = 1'b1;
        in_data  = d;
        while (!got && n < 300) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_data  = {16'($urandom), $urandom};
        chk("accepted", 48'(got), 48'd1);
    endtask

    task automatic send_rand();
        logic [47:0] d;
        d = {16'($urandom), $urandom};
        send(d, ref_slayer(d));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        chk("wait_valid", 48'(out_valid), 48'd1);
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step();
            n++;
        end
        chk("drain", 48'(exp_q.size()), 48'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1; in_data = '0;
        step();
        @(negedge clk);
        chk("rst_in_ready",  48'(in_ready),  48'd0);
        chk("rst_out_valid", 48'(out_valid), 48'd0);
        chk("rst_out_data",  48'(out_data),  48'd0);
        chk("rst_busy",      48'(busy),      48'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 48'(in_ready), 48'd1);
        step();

        // Known-answer vectors
        send(48'h0, 32'hEFA72C4D);
        @(negedge clk);
        chk("busy_run", 48'(busy), 48'd1);
        step();
        drain();
        send(48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB);
        drain();

        repeat (30) begin
            send_rand();
        end
        drain();

        // Output back-pressure, then release together with a new word
        out_ready = 1'b0;
        send_rand();
        wait_valid();
        repeat (20) begin
            @(negedge clk);
            chk("stall_in_ready",  48'(in_ready),  48'd0);
            chk("stall_out_valid", 48'(out_valid), 48'd1);
            step();
        end
        out_ready = 1'b1;
        send_rand();
        drain();

        // Abort mid-RUN with a competing input
        send_rand();
        repeat (4) step();
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = {16'($urandom), $urandom};
        @(negedge clk);
        chk("abort_in_ready", 48'(in_ready), 48'd0);
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle_ready", 48'(in_ready),  48'd1);
        chk("abort_busy",       48'(busy),      48'd0);
        chk("abort_out_valid",  48'(out_valid), 48'd0);
        step();
        repeat (15) step();
        send_rand();
        drain();

        // Reset while a result is waiting in DONE
        out_ready = 1'b0;
        send_rand();
        wait_valid();
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_done_out_valid", 48'(out_valid), 48'd0);
        step();
        @(negedge clk);
        chk("rst2_in_ready",  48'(in_ready),  48'd0);
        chk("rst2_out_valid", 48'(out_valid), 48'd0);
        chk("rst2_out_data",  48'(out_data),  48'd0);
        chk("rst2_busy",      48'(busy),      48'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_release_ready", 48'(in_ready), 48'd1);
        step();
        repeat (12) step();
        send_rand();
        drain();

        // Back-to-back stream
        have_last = 1'b0;
        b2b       = 1'b1;
        repeat (100) begin
            send_rand();
        end
        drain();
        b2b = 1'b0;

        chk("final_queue_empty", 48'(exp_q.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
